// File: rtl/dmem_pkg.sv
// Shared types and helpers for the byte-lane data memory: access size
// encodings, run/program state, lane-enable, misalignment and store-data
// replication helpers.
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic {
        RUN  = 1'b0,
        PROG = 1'b1
    } state_e;

    // Byte lanes touched by an aligned access of the given size at offset off.
    // Size 2'b11 behaves as a word.
    function automatic logic [3:0] lane_en(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] en;
        case (size)
            SZ_BYTE: en = 4'b0001 << off;
            SZ_HALF: en = off[1] ? 4'b1100 : 4'b0011;
            default: en = 4'b1111;
        endcase
        return en;
    endfunction

    // Halfwords must be 2-byte aligned, words (and size 11) 4-byte aligned.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        logic mis;
        case (size)
            SZ_BYTE: mis = 1'b0;
            SZ_HALF: mis = off[0];
            default: mis = (off != 2'b00);
        endcase
        return mis;
    endfunction

    // Right-justified store data replicated across the lanes so the lane
    // enables alone select where it lands.
    function automatic logic [31:0] replicate_wdat(input logic [1:0] size, input logic [31:0] w);
        logic [31:0] r;
        case (size)
            SZ_BYTE: r = {4{w[7:0]}};
            SZ_HALF: r = {2{w[15:0]}};
            default: r = w;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dmem_bytelane_if.sv
// CPU load/store bus of the data memory. Signal suffixes are from the
// memory's point of view; the CPU side uses the master modport.
interface dmem_bytelane_if #(
    parameter int ADDR_W = 32
) ();
    logic              req_i;
    logic              we_i;
    logic [1:0]        size_i;
    logic              unsigned_i;
    logic [ADDR_W-1:0] adr_i;
    logic [31:0]       wdat_i;
    logic              ready_o;
    logic              rvalid_o;
    logic [31:0]       rdat_o;
    logic              misalign_o;

    modport master (
        output req_i, we_i, size_i, unsigned_i, adr_i, wdat_i,
        input  ready_o, rvalid_o, rdat_o, misalign_o
    );

    modport slave (
        input  req_i, we_i, size_i, unsigned_i, adr_i, wdat_i,
        output ready_o, rvalid_o, rdat_o, misalign_o
    );
endinterface

// File: rtl/dmem_bram.sv
// Single-port inferred RAM, one 8-bit array per byte lane, per-lane write
// enable and a 1-cycle registered read. Contents have no reset.
module dmem_bram #(
    parameter int DEPTH_WORDS = 16384,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic             clk_i,
    input  logic [IDX_W-1:0] addr_i,
    input  logic [3:0]       be_i,
    input  logic [31:0]      wdat_i,
    input  logic             re_i,
    output logic [31:0]      rdat_o
);

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] mem_q [DEPTH_WORDS];
            logic [7:0] rd_q;

            // Lane write and registered read; read data holds when not read.
            always_ff @(posedge clk_i) begin
                if (be_i[gi]) begin
                    mem_q[addr_i] <= wdat_i[gi*8 +: 8];
                end
                if (re_i) begin
                    rd_q <= mem_q[addr_i];
                end
            end

            assign rdat_o[gi*8 +: 8] = rd_q;
        end
    endgenerate

endmodule

// File: rtl/dmem_bytelane.sv
// Data memory for the CPU load/store path: byte/half/word stores via lane
// enables, 1-cycle registered loads with a valid strobe, misalignment
// detection, and a RUN/PROG FSM that hands the RAM port to the UART
// programmer. Optional macro DMEM_LOAD_EXT_EN enables in-memory load
// byte/half extraction with sign or zero extension.
module dmem_bytelane
    import dmem_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DEPTH_WORDS = 16384,
    parameter int UPG_ADR_W   = 14
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    dmem_bytelane_if.slave       bus,
    input  logic                 upg_rst_i,
    input  logic                 upg_wen_i,
    input  logic [UPG_ADR_W-1:0] upg_adr_i,
    input  logic [31:0]          upg_dat_i,
    input  logic                 upg_done_i,
    output logic                 prog_mode_o
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    state_e           state_q, state_d;
    logic             run;
    logic [1:0]       off;
    logic             mis;
    logic             cpu_ld, cpu_st;
    logic [IDX_W-1:0] ram_addr;
    logic [3:0]       ram_be;
    logic [31:0]      ram_wdat;
    logic             ram_re;
    logic [31:0]      ram_rdat;
    logic             rvalid_q;
    logic             misalign_q;
    logic             zero_q;
    logic             unused_bits;

    // Upper address bits alias by design; unsigned_i only matters with extraction.
    assign unused_bits = ^{bus.adr_i, bus.unsigned_i};

    // FSM state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: programmer active while out of reset and not done.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (!upg_rst_i && !upg_done_i) state_d = PROG;
            PROG:    if (upg_rst_i || upg_done_i)   state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    // FSM outputs.
    always_comb begin
        prog_mode_o = (state_q == PROG);
        bus.ready_o = (state_q != PROG);
    end

    // CPU request decode; requests only count in RUN.
    always_comb begin
        run    = (state_q == RUN);
        off    = bus.adr_i[1:0];
        mis    = is_misaligned(bus.size_i, off);
        cpu_ld = run && bus.req_i && !bus.we_i;
        cpu_st = run && bus.req_i &&  bus.we_i;
    end

    // RAM port mux: programmer owns the port in PROG, CPU in RUN.
    always_comb begin
        ram_addr = bus.adr_i[IDX_W+1:2];
        ram_be   = 4'b0000;
        ram_wdat = replicate_wdat(bus.size_i, bus.wdat_i);
        ram_re   = 1'b0;
        if (!run) begin
            ram_addr = upg_adr_i;
            ram_be   = {4{upg_wen_i}};
            ram_wdat = upg_dat_i;
        end else begin
            ram_be = (cpu_st && !mis) ? lane_en(bus.size_i, off) : 4'b0000;
            ram_re = cpu_ld && !mis;
        end
    end

    dmem_bram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_bram (
        .clk_i  (clk_i),
        .addr_i (ram_addr),
        .be_i   (ram_be),
        .wdat_i (ram_wdat),
        .re_i   (ram_re),
        .rdat_o (ram_rdat)
    );

    // Response strobes; zero_q forces rdat_o to 0 after reset or a misaligned
    // load and is only updated by loads, so rdat_o holds between loads.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rvalid_q   <= 1'b0;
            misalign_q <= 1'b0;
            zero_q     <= 1'b1;
        end else begin
            rvalid_q   <= cpu_ld;
            misalign_q <= (cpu_ld || cpu_st) && mis;
            if (cpu_ld) begin
                zero_q <= mis;
            end
        end
    end

    assign bus.rvalid_o   = rvalid_q;
    assign bus.misalign_o = misalign_q;

`ifdef DMEM_LOAD_EXT_EN
    logic [1:0] ld_size_q;
    logic [1:0] ld_off_q;
    logic       ld_uns_q;

    // Load attributes captured with the request for extraction next cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ld_size_q <= SZ_WORD;
            ld_off_q  <= 2'b00;
            ld_uns_q  <= 1'b0;
        end else if (cpu_ld) begin
            ld_size_q <= bus.size_i;
            ld_off_q  <= off;
            ld_uns_q  <= bus.unsigned_i;
        end
    end

    function automatic logic [31:0] load_format(input logic [31:0] w, input logic [1:0] sz,
                                                input logic [1:0] o, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (o)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        h = o[1] ? w[31:16] : w[15:0];
        case (sz)
            SZ_BYTE: r = {{24{~uns & b[7]}}, b};
            SZ_HALF: r = {{16{~uns & h[15]}}, h};
            default: r = w;
        endcase
        return r;
    endfunction

    // Load data: addressed byte/half shifted to bit 0 and extended.
    always_comb begin
        bus.rdat_o = zero_q ? 32'h0 : load_format(ram_rdat, ld_size_q, ld_off_q, ld_uns_q);
    end
`else
    // Load data: raw aligned word; extraction happens in writeback.
    always_comb begin
        bus.rdat_o = zero_q ? 32'h0 : ram_rdat;
    end
`endif

endmodule

// File: doc/dmem_bytelane.md
Name: dmem_bytelane

Overview:
Parametrised data memory for the CPU load/store path, succeeding the word-only data RAM. Adds byte/halfword stores via per-lane write enables, a 1-cycle registered read with a valid strobe, and misalignment detection. Also adds an explicit run/program mode FSM that muxes the UART programmer write port onto the same single-port RAM. Sits between ALU/decoder and writeback; programmer side is driven by the UART programmer, already synchronised to clk_i.

Parameters:
ADDR_W, 32, byte-address width of adr_i
DEPTH_WORDS, 16384, number of 32-bit words; power of two
UPG_ADR_W, 14, word-address width of upg_adr_i; must equal log2(DEPTH_WORDS)

Ports:
clk_i  in  1  single system clock
rst_i  in  1  synchronous, active-high reset
req_i  in  1  CPU access request, one per cycle
we_i  in  1  1=store, 0=load
size_i  in  2  00 byte, 01 half, 10 word, 11 treated as word
unsigned_i  in  1  zero-extend load; used only with DMEM_LOAD_EXT_EN
adr_i  in  ADDR_W  byte address
wdat_i  in  32  store data, right-justified
ready_o  out  1  1 in RUN, 0 in PROG
rvalid_o  out  1  load data valid, one-cycle pulse
rdat_o  out  32  load data
misalign_o  out  1  misaligned-access pulse
upg_rst_i  in  1  programmer held in reset (1 = normal mode)
upg_wen_i  in  1  programmer word write
upg_adr_i  in  UPG_ADR_W  programmer word address
upg_dat_i  in  32  programmer write data
upg_done_i  in  1  programming finished
prog_mode_o  out  1  1 while in PROG

Behaviour:
- Reset (rst_i): state=RUN; rvalid_o=0, misalign_o=0, rdat_o=0, prog_mode_o=0, ready_o=1. RAM contents are not cleared.
- FSM RUN -> PROG when upg_rst_i=0 and upg_done_i=0, taking effect next cycle.
- FSM PROG -> RUN when upg_rst_i=1 or upg_done_i=1, taking effect next cycle.
- prog_mode_o = (state==PROG). ready_o = !prog_mode_o.
- PROG mode:
  - CPU req_i ignored: no write, no rvalid_o.
  - upg_wen_i=1 writes all 4 lanes of word upg_adr_i with upg_dat_i.
  - A CPU request in the cycle PROG is entered is still serviced, since the state is still RUN in that cycle.
- RUN mode: word index = adr_i[log2(DEPTH_WORDS)+1:2]. Upper bits are ignored, so addresses alias.
- Misalignment: half with adr_i[0]=1, or word with adr_i[1:0]!=0.
  - Misaligned store: no lanes written.
  - Misaligned load: rvalid_o=1 with rdat_o=0.
  - Either case: misalign_o=1 for one cycle, aligned with rvalid_o timing (next cycle).
- Store lane enables:
  - byte: lane adr_i[1:0]; wdat_i[7:0] replicated to all lanes.
  - half: lanes {2*adr_i[1]+1, 2*adr_i[1]}; wdat_i[15:0] replicated.
  - word: all lanes.
- Load: req_i & !we_i in cycle N gives rvalid_o=1 and rdat_o in cycle N+1. Back-to-back loads sustain 1/cycle.
- rdat_o holds its value when rvalid_o=0.
- A store in cycle N followed by a load of the same word in N+1 returns the new data. The RAM write is committed at the end of N.
- rst_i asserted mid-PROG: return to RUN, written words preserved. Re-enters PROG next cycle if upg_rst_i=0 and upg_done_i=0 still hold.

Optional Feature:
DMEM_LOAD_EXT_EN:
- Defined: rdat_o is the addressed byte or half shifted to bit 0. It is sign-extended, or zero-extended when unsigned_i=1. size_i, unsigned_i and adr_i[1:0] are registered with the request.
- Undefined: rdat_o is the raw aligned 32-bit word and unsigned_i is unused. Extraction is done in writeback.

Decomposition:
- Package dmem_pkg:
  - size encodings SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10
  - state enum {RUN, PROG}
  - lane-enable function of (size, adr[1:0])
- Sub-module dmem_bram: single-port, 4 byte-lane write enables, 1-cycle registered read, DEPTH_WORDS deep, inferred (no IP core).

Test Plan:
- sw 0x12345678 @0x10; lw @0x10 next cycle -> rvalid_o=1 one cycle later, rdat_o=0x12345678, misalign_o=0.
- sb 0x000000AB @0x11; lw @0x10 -> 0x1234AB78. Then sh 0xBEEF @0x12; lw @0x10 -> 0xBEEFAB78.
- lw @0x12, then sh @0x13 -> misalign_o=1 and rvalid_o=1 with rdat_o=0 for the load; the store writes nothing; lw @0x10 still 0xBEEFAB78.
- Programming sequence:
  - upg_rst_i=0 -> prog_mode_o=1, ready_o=0 next cycle.
  - upg write word 5=0xDEADBEEF; a concurrent CPU sw @0x14=0x1 is ignored.
  - upg_done_i=1 -> RUN next cycle.
  - lw @0x14 -> 0xDEADBEEF.
- rst_i pulsed mid-PROG with upg_rst_i=1 -> RUN, ready_o=1, previously programmed words intact.
- With DMEM_LOAD_EXT_EN, word @0x10=0xBEEFAB78:
  - lb @0x11 -> 0xFFFFFFAB; lbu -> 0x000000AB.
  - lh @0x12 -> 0xFFFFBEEF; lhu -> 0x0000BEEF.
